fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised successor to the single-register PC / IF-ID fetch path.
- Owns the fetch PC and issues requests to a variable-latency instruction memory using a two-phase grant/response handshake.
- Buffers up to DEPTH fetched instructions, together with PC+4 per entry, for the decode stage.
- Supports decode back-pressure and branch/jump redirect with flush. It replaces the stall-only write_pc_ir / branch coupling.

Parameters:
ADDR_W, 32, instruction address width
INST_W, 32, instruction word width
DEPTH, 4, queue entries; power of two, 2..16
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address; held stable while imem_req=1
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  INST_W  instruction word
redirect  in  1  branch/jump taken; flush and refetch
redirect_addr  in  ADDR_W  new fetch PC
id_ready  in  1  decode can consume this cycle
id_valid  out  1  queue head valid
id_inst  out  INST_W  head instruction
id_pc  out  ADDR_W  head PC+4 (matches existing if_pc semantics)
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue empty; FSM=IDLE.
  - Outputs: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=0, count=0.
  - Deasserting reset mid-transaction discards any in-flight response. The memory must also be reset.
- At most one outstanding request.
- Space check: count + outstanding < DEPTH, so a push never overflows.
- FSM states:
  - IDLE: imem_req=0. Go to REQ next cycle if space and no redirect.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_gnt: fetch_pc += 4 (wraps modulo 2^ADDR_W); go to WAIT.
    - Without grant: stay in REQ; address unchanged.
  - WAIT: imem_req=0; await imem_rvalid.
    - On rvalid: push {fetch_addr+4, rdata}. Go to REQ if space after the push accounting, else IDLE.
  - DROP: await imem_rvalid and discard the data; then go to REQ, using redirect_addr already loaded into fetch_pc.
- Redirect (highest priority, any state):
  - Queue cleared next cycle; count=0, id_valid=0.
  - fetch_pc <= redirect_addr.
  - From WAIT, or from REQ with imem_gnt in the same cycle: go to DROP.
  - From REQ without gnt: stay in REQ with the new address. The address change is allowed only on redirect.
  - From IDLE: go to REQ.
  - rvalid in the same cycle as redirect: data discarded; the request is no longer outstanding, so go to REQ.
  - A pop in the same cycle as redirect is ignored.
- Dequeue:
  - Pop when id_valid && id_ready.
  - id_inst/id_pc are driven combinationally from the head entry.
  - First-word latency: an rvalid in cycle N gives id_valid=1 in cycle N+1. No bypass.
- Simultaneous push and pop: allowed at any occupancy; count unchanged.
- Full queue: no new request is issued. Empty queue: id_valid=0, and id_inst/id_pc hold the last value.
- Pointers are log2(DEPTH) bits and wrap naturally.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_redirects[31:0] and perf_starve[31:0].
  - perf_redirects increments per redirect cycle.
  - perf_starve increments per cycle with id_ready=1 && id_valid=0.
  - Both counters reset to 0, saturate at 0xFFFFFFFF, and are not cleared by redirect.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- macros.v:
  - InstAddrBus and InstBus ranges.
  - Fetch FSM state encodings FQ_IDLE/FQ_REQ/FQ_WAIT/FQ_DROP (2-bit).
  - PC increment constant 4.
- Sub-module fetch_fifo: parametrised synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: head data, count.
  - Width = ADDR_W+INST_W.
- fetch_queue instantiates fetch_fifo and holds the FSM and PC logic.

Test Plan:
- Reset release, memory grants every cycle, rvalid one cycle later, id_ready=1 → request addresses 0,4,8,…; first id_valid 2 cycles after the first grant; id_pc=4, inst matches word 0.
- id_ready=0 with DEPTH=4 → exactly 4 grants, count=4, imem_req stays 0. Then id_ready=1 for 1 cycle → one pop and a new request to 0x10.
- Redirect to 0x100 while in WAIT for 0x08 → the 0x08 response is discarded; count=0 next cycle; next request addr=0x100; first id_pc=0x104.
- Redirect coincident with rvalid → data not pushed; next imem_addr=redirect_addr with no DROP cycle.
- imem_gnt withheld 5 cycles → imem_addr stable and imem_req held; fetch_pc advances only on grant.
- RESET_PC=0xFFFFFFFC → fetch addresses 0xFFFFFFFC then 0x00000000 (wrap); id_pc of the first entry = 0x00000000.
- FETCH_PERF_EN, 3 redirects plus 7 starved cycles → perf_redirects=3, perf_starve=7; async reset mid-run → both counters 0 immediately.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: FSM encoding, PC step, saturating counter helper.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_WAIT = 2'd2,
    FQ_DROP = 2'd3
  } fq_state_e;

  localparam int unsigned PC_INC = 4;
  localparam int unsigned PERF_W = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory and decode-side handshake bundle for fetch_queue.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              id_ready;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, count,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, count,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_addr, id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head shows the last valid entry while empty.
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     last_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop && (cnt != '0);
  assign push_ok = push && ((cnt != CNT_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      // Remember the head so it stays visible once the queue drains or flushes.
      if (cnt != '0) last_q <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push_ok, pop_ok})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign head  = (cnt != '0) ? mem[rd_ptr] : last_q;
  assign count = cnt;
endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner + request FSM feeding a DEPTH-entry {PC+4, inst} queue.
// Optional FETCH_PERF_EN adds saturating redirect / decode-starve counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  , output logic [PERF_W-1:0] perf_redirects
  , output logic [PERF_W-1:0] perf_starve
`endif
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned W     = ADDR_W + INST_W;

  fq_state_e         state;
  logic              req_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [W-1:0]      head;
  logic [CNT_W-1:0]  cnt;
  logic              id_valid, push, pop, room;

  assign id_valid = (cnt != '0);
  assign pop      = id_valid && bus.id_ready && !bus.redirect;
  assign push     = (state == FQ_WAIT) && bus.imem_rvalid && !bus.redirect;
  // Space left after this push lands, counting a same-cycle pop.
  assign room     = pop || (cnt < CNT_W'(DEPTH - 1));

  fetch_fifo #(.W(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   ({fetch_pc, bus.imem_rdata}),
    .head  (head),
    .count (cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FQ_IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_addr;
      // Only a granted request whose response is still pending forces DROP.
      case (state)
        FQ_REQ: begin
          state <= bus.imem_gnt ? FQ_DROP : FQ_REQ;
          req_q <= !bus.imem_gnt;
        end
        FQ_WAIT, FQ_DROP: begin
          state <= bus.imem_rvalid ? FQ_REQ : FQ_DROP;
          req_q <= bus.imem_rvalid;
        end
        default: begin
          state <= FQ_REQ;
          req_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        FQ_IDLE: if (cnt < CNT_W'(DEPTH)) begin
          state <= FQ_REQ;
          req_q <= 1'b1;
        end
        FQ_REQ: if (bus.imem_gnt) begin
          fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
          state    <= FQ_WAIT;
          req_q    <= 1'b0;
        end
        FQ_WAIT: if (bus.imem_rvalid) begin
          state <= room ? FQ_REQ : FQ_IDLE;
          req_q <= room;
        end
        FQ_DROP: if (bus.imem_rvalid) begin
          state <= FQ_REQ;
          req_q <= 1'b1;
        end
        default: begin
          state <= FQ_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = fetch_pc;
  assign bus.id_valid  = id_valid;
  assign bus.id_inst   = head[INST_W-1:0];
  assign bus.id_pc     = head[W-1:INST_W];
  assign bus.count     = cnt;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_redirects <= '0;
      perf_starve    <= '0;
    end else begin
      if (bus.redirect)               perf_redirects <= sat_inc(perf_redirects);
      if (bus.id_ready && !id_valid)  perf_starve    <= sat_inc(perf_starve);
    end
  end
`endif
endmodule
